// File: rtl/pea_token_writer.sv
`default_nettype none
// ============================================================================
//  Module      : pea_token_writer
//  Description : Host-side writer that streams one command token and its
//                data tokens into the PEA input FIFOs. It then pulses
//                invoke and waits for firing-complete (FC).
//                Optional macro PEA_TW_ATOMIC_EN: the command is written only
//                once the data FIFO can take the whole burst.
//  Revision    : 1.0  initial release
// ============================================================================
module pea_token_writer #(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [word_size-1:0] req_command,
    input  logic [5:0]           req_count,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [word_size-1:0] src_data,
    input  logic [word_size-1:0] command_free,
    input  logic [word_size-1:0] data_free,
    output logic                 wr_command,
    output logic                 wr_data,
    output logic [word_size-1:0] command_out,
    output logic [word_size-1:0] data_out,
    output logic                 invoke,
    input  logic                 FC,
    output logic                 busy,
    output logic [15:0]          issued_count
);

    // Burst length limit. A FIFO shallower than 32 words lowers it, so that
    // an atomic burst can always fit and CMD cannot deadlock.
    localparam logic [5:0] c_MAX_COUNT = 6'((buffer_size < 32) ? buffer_size : 32);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CMD     = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_INVOKE  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_FC = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [word_size-1:0] r_cmd;
    logic [5:0]           r_count;
    logic                 r_wr_command;
    logic                 r_wr_data;
    logic                 r_invoke;
    logic [word_size-1:0] r_command_out;
    logic [word_size-1:0] r_data_out;
    logic [15:0]          r_issued_count;

    logic [5:0]           w_req_count_clamped;
    logic                 w_cmd_go;
    logic                 w_latch_req;
    logic                 w_src_fire;
    logic                 w_issue_done;
    logic                 w_wr_command_nxt;
    logic                 w_wr_data_nxt;
    logic                 w_invoke_nxt;

    assign w_req_count_clamped = (req_count > c_MAX_COUNT) ? c_MAX_COUNT : req_count;

`ifdef PEA_TW_ATOMIC_EN
    // The command goes out only when the whole burst fits in the data FIFO.
    assign w_cmd_go = (command_free != '0) && (data_free >= word_size'(r_count));
`else
    assign w_cmd_go = (command_free != '0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = c_ST_CMD;
                end
            end
            c_ST_CMD: begin
                if (w_cmd_go) begin
                    w_state_nxt = (r_count == 6'd0) ? c_ST_INVOKE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_src_fire && (r_count == 6'd1)) begin
                    w_state_nxt = c_ST_INVOKE;
                end
            end
            c_ST_INVOKE: begin
                w_state_nxt = c_ST_WAIT_FC;
            end
            c_ST_WAIT_FC: begin
                if (FC) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode: handshakes and the next values of the registered strobes
    always_comb begin
        req_ready        = (r_state == c_ST_IDLE) && !rst;
        src_ready        = (r_state == c_ST_DATA) && (data_free != '0);
        busy             = (r_state != c_ST_IDLE);
        w_latch_req      = (r_state == c_ST_IDLE) && req_valid;
        w_src_fire       = src_ready && src_valid;
        w_issue_done     = (r_state == c_ST_WAIT_FC) && FC;
        w_wr_command_nxt = (r_state == c_ST_CMD) && w_cmd_go;
        w_wr_data_nxt    = w_src_fire;
        w_invoke_nxt     = (r_state == c_ST_INVOKE);
    end

    // Registered strobes, tokens, request latch and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd          <= '0;
            r_count        <= '0;
            r_wr_command   <= 1'b0;
            r_wr_data      <= 1'b0;
            r_invoke       <= 1'b0;
            r_command_out  <= '0;
            r_data_out     <= '0;
            r_issued_count <= '0;
        end else begin
            r_wr_command <= w_wr_command_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_invoke     <= w_invoke_nxt;
            if (w_latch_req) begin
                r_cmd   <= req_command;
                r_count <= w_req_count_clamped;
            end
            if (w_wr_command_nxt) begin
                r_command_out <= r_cmd;
            end
            if (w_src_fire) begin
                r_data_out <= src_data;
                r_count    <= r_count - 6'd1;
            end
            if (w_issue_done) begin
                r_issued_count <= r_issued_count + 16'd1;
            end
        end
    end

    assign wr_command   = r_wr_command;
    assign wr_data      = r_wr_data;
    assign invoke       = r_invoke;
    assign command_out  = r_command_out;
    assign data_out     = r_data_out;
    assign issued_count = r_issued_count;

endmodule
`default_nettype wire

// File: tb/tb_pea_token_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pea_token_writer
//  Description : Self-checking bench for pea_token_writer. A transaction-level
//                scoreboard holds the tokens each request should write. It is
//                checked against the FIFO strobes, the invoke pulse and the
//                completion count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pea_token_writer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_command;
    logic [5:0]  req_count;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] src_data;
    logic [15:0] command_free;
    logic [15:0] data_free;
    logic        wr_command;
    logic        wr_data;
    logic [15:0] command_out;
    logic [15:0] data_out;
    logic        invoke;
    logic        FC;
    logic        busy;
    logic [15:0] issued_count;

    pea_token_writer #(.word_size(16), .buffer_size(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_command(req_command), .req_count(req_count),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .command_free(command_free), .data_free(data_free),
        .wr_command(wr_command), .wr_data(wr_data),
        .command_out(command_out), .data_out(data_out),
        .invoke(invoke), .FC(FC), .busy(busy), .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];          // {is_command, token}, in write order
    logic [15:0] exp_issued = 16'd0;
    logic [15:0] g_data[32];
    int          cyc = 0;
    int          last_strobe = -10;
    int          inv_cnt = 0;
    int          inv_start = 0;
    int          cmd_cnt = 0;
    int          wd_cnt = 0;
    logic        prev_inv = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Strobe monitor: every FIFO write must be the next scoreboard token
    always @(negedge clk) begin
        if (!rst) begin
            logic [16:0] got;
            logic [16:0] exp;
            cyc++;
            if (wr_command || wr_data) begin
                check("strobe_excl", longint'(wr_command && wr_data), 0);
                got = wr_command ? {1'b1, command_out} : {1'b0, data_out};
                check("tok_avail", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    check("token", got, exp);
                end
                last_strobe = cyc;
                if (wr_command) cmd_cnt++;
                if (wr_data) wd_cnt++;
            end
            if (invoke) begin
                check("inv_single", longint'(prev_inv), 0);
                check("inv_after_last_write", cyc - last_strobe, 1);
                check("inv_all_written", exp_q.size(), 0);
                inv_cnt++;
            end
            prev_inv = invoke;
            check("src_rdy_needs_room", longint'(src_ready && (data_free == 16'd0)), 0);
            check("rdy_vs_busy", longint'(req_ready), longint'(!busy));
        end else begin
            prev_inv = 1'b0;
        end
    end

    task automatic rand_free(input bit rnd);
        if (rnd) begin
            command_free = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 1024));
            data_free    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 1024));
        end
    endtask

    task automatic start_req(input logic [15:0] cmd, input int cnt, input bit rnd);
        int n;
        int t;
        bit fired;
        n = (cnt > 32) ? 32 : cnt;
        exp_q.push_back({1'b1, cmd});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, g_data[i]});
        inv_start   = inv_cnt;
        req_valid   = 1'b1;
        req_command = cmd;
        req_count   = 6'(cnt);
        fired = 1'b0;
        t = 0;
        while (!fired && t < 200) begin
            rand_free(rnd);
            @(negedge clk);
            fired = req_ready;
            @(posedge clk); #1;
            t++;
        end
        req_valid = 1'b0;
        check("req_handshake", longint'(fired), 1);
    endtask

    task automatic send_data(input int lo, input int hi, input bit rnd);
        int  idx;
        int  t;
        bit  fired;
        idx = lo;
        t = 0;
        while (idx < hi && t < 3000) begin
            src_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            src_data  = g_data[idx];
            rand_free(rnd);
            @(negedge clk);
            fired = src_valid && src_ready;
            @(posedge clk); #1;
            if (fired) idx++;
            t++;
        end
        src_valid = 1'b0;
        check("data_sent", idx, hi);
    endtask

    task automatic finish_req(input bit rnd);
        int t;
        t = 0;
        while (inv_cnt == inv_start && t < 300) begin
            rand_free(rnd);
            @(posedge clk); #1;
            t++;
        end
        check("invoke_seen", inv_cnt - inv_start, 1);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        FC = 1'b1;
        @(posedge clk); #1;
        FC = 1'b0;
        exp_issued = exp_issued + 16'd1;
        check("issued_count", issued_count, exp_issued);
        check("idle_after_fc", longint'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
        check("invoke_once", inv_cnt - inv_start, 1);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) g_data[i] = 16'($urandom);
    endtask

    task automatic full_req(input logic [15:0] cmd, input int cnt, input bit rnd);
        int n;
        n = (cnt > 32) ? 32 : cnt;
        start_req(cmd, cnt, rnd);
        send_data(0, n, rnd);
        finish_req(rnd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int w0;
        rst = 1'b1; req_valid = 1'b0; req_command = '0; req_count = '0;
        src_valid = 1'b0; src_data = '0; command_free = 16'd1024; data_free = 16'd1024; FC = 1'b0;
        #1;
        check("rst_req_ready", longint'(req_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_wr", longint'({wr_command, wr_data, invoke, src_ready}), 0);
        check("rst_issued", issued_count, 0);
        check("rst_tokens", {command_out, data_out}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", longint'(req_ready), 1);

        // Reference transaction: command 0x0143 with data 5, -2, 7
        g_data[0] = 16'h0005; g_data[1] = 16'hFFFE; g_data[2] = 16'h0007;
        @(posedge clk); #1;
        full_req(16'h0143, 3, 1'b0);

        // Zero-length request: command then invoke
        c0 = cmd_cnt; w0 = wd_cnt;
        full_req(16'h0200, 0, 1'b0);
        check("cnt0_cmd", cmd_cnt - c0, 1);
        check("cnt0_nodata", wd_cnt - w0, 0);

        // Command FIFO full for 8 cycles
        command_free = 16'd0; data_free = 16'd1024;
        fill_random(2);
        start_req(16'h0311, 2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("cmdfull_no_wr", longint'(wr_command), 0);
            check("cmdfull_busy", longint'(busy), 1);
            check("cmdfull_req_ready", longint'(req_ready), 0);
        end
        command_free = 16'd1;
        @(posedge clk); #1;
        check("cmdfree_wr", longint'(wr_command), 1);
        check("cmdfree_val", command_out, 16'h0311);
        send_data(0, 2, 1'b0);
        finish_req(1'b0);

        // Data FIFO full at the start of a 4-token burst
        command_free = 16'd1024; data_free = 16'd0;
        fill_random(4);
        c0 = cmd_cnt; w0 = wd_cnt;
        start_req(16'h0A21, 4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            src_valid = 1'b1; src_data = g_data[0];
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
        check("stall_no_data", wd_cnt - w0, 0);
`ifdef PEA_TW_ATOMIC_EN
        check("atomic_cmd_held", cmd_cnt - c0, 0);
`else
        check("cmd_before_room", cmd_cnt - c0, 1);
`endif
        data_free = 16'd10;
        send_data(0, 4, 1'b0);
        finish_req(1'b0);
        check("burst4_writes", wd_cnt - w0, 4);

        // Oversized count is clamped to 32 tokens
        fill_random(32);
        w0 = wd_cnt;
        full_req(16'h7FFF, 63, 1'b0);
        check("clamp_writes", wd_cnt - w0, 32);

        // Randomized requests with random FIFO room and source gaps
        for (int r = 0; r < 40; r++) begin
            int cnt;
            cnt = $urandom_range(0, 40);
            fill_random(32);
            full_req(16'($urandom), cnt, 1'b1);
        end
        command_free = 16'd1024; data_free = 16'd1024;

        // Reset in the middle of a 5-token burst, after 2 tokens
        fill_random(5);
        start_req(16'h5505, 5, 1'b0);
        send_data(0, 2, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_wr_command", longint'(wr_command), 0);
        check("midrst_wr_data", longint'(wr_data), 0);
        check("midrst_invoke", longint'(invoke), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_src_ready", longint'(src_ready), 0);
        check("midrst_req_ready", longint'(req_ready), 0);
        check("midrst_command_out", command_out, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_issued", issued_count, 0);
        exp_q.delete();
        exp_issued = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_req_ready", longint'(req_ready), 1);
        check("rel_no_writes", longint'({wr_command, wr_data}), 0);
        @(posedge clk); #1;
        check("rel_idle", longint'(busy), 0);
        check("rel_no_writes2", longint'({wr_command, wr_data}), 0);

        // FC while idle has no effect
        FC = 1'b1;
        @(posedge clk); #1;
        FC = 1'b0;
        check("spurious_fc_count", issued_count, exp_issued);
        check("spurious_fc_idle", longint'(busy), 0);

        // Normal operation resumes after reset
        fill_random(6);
        full_req(16'h0C0D, 6, 1'b1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
